// File: rtl/random_word_packer_if.sv
// rtl/random_word_packer_if.sv - bit input / word output bundle for the random word packer
interface random_word_packer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     bit_in;
    logic                     bit_valid;
    logic                     debias_en;
    logic                     clear;
    logic [WIDTH-1:0]         word_data;
    logic                     word_valid;
    logic                     word_ready;
    logic [$clog2(DEPTH):0]   fill_level;
    logic                     overflow;

    modport master (
        output bit_in, bit_valid, debias_en, clear, word_ready,
        input  word_data, word_valid, fill_level, overflow
    );

    modport slave (
        input  bit_in, bit_valid, debias_en, clear, word_ready,
        output word_data, word_valid, fill_level, overflow
    );
endinterface

// File: rtl/random_word_packer.sv
// rtl/random_word_packer.sv - von Neumann debiaser, word assembler and FWFT output FIFO
module random_word_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    random_word_packer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, HAVE_FIRST = 1'b1} pair_state_t;

    pair_state_t      state;
    pair_state_t      state_nxt;
    logic             first_bit;
    logic             capture;
    logic             emit;
    logic             emit_bit;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [NW-1:0]    cnt;
    logic             push;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    fill;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             ovf;

    // Pair FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            first_bit <= 1'b0;
        end else if (bus.clear) begin
            state     <= IDLE;
            first_bit <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) first_bit <= bus.bit_in;
        end
    end

    // Pair FSM: next state
    always_comb begin
        state_nxt = state;
        if (!bus.debias_en) begin
            state_nxt = IDLE;
        end else if (bus.bit_valid) begin
            case (state)
                IDLE:       state_nxt = HAVE_FIRST;
                HAVE_FIRST: state_nxt = IDLE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // Pair FSM: outputs; a differing pair emits its first bit (10 -> 1, 01 -> 0)
    always_comb begin
        capture  = 1'b0;
        emit     = 1'b0;
        emit_bit = 1'b0;
        if (!bus.debias_en) begin
            emit     = bus.bit_valid;
            emit_bit = bus.bit_in;
        end else if (bus.bit_valid) begin
            case (state)
                IDLE:       capture = 1'b1;
                HAVE_FIRST: begin
                    emit     = (first_bit != bus.bit_in);
                    emit_bit = first_bit;
                end
                default:    capture = 1'b0;
            endcase
        end
    end

    assign shreg_nxt = {shreg[WIDTH-2:0], emit_bit};
    assign push      = emit && (cnt == NW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (bus.clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (emit) begin
            shreg <= shreg_nxt;
            cnt   <= push ? '0 : cnt + 1'b1;
        end
    end

    assign full  = (fill == CW'(DEPTH));
    assign pop   = bus.word_valid && bus.word_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            ovf    <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (push && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !bus.clear) mem[wr_ptr] <= shreg_nxt;
    end

    assign bus.word_valid = (fill != '0);
    assign bus.word_data  = bus.word_valid ? mem[rd_ptr] : '0;
    assign bus.fill_level = fill;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_random_word_packer.sv
// tb/tb_random_word_packer.sv - directed self-checking bench for random_word_packer
module tb_random_word_packer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    random_word_packer_if #(.WIDTH(8), .DEPTH(4)) bus ();

    random_word_packer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pop_word(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(bus.word_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.word_data), 32'(exp));
        bus.word_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.word_ready = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.debias_en  = 1'b0;
        bus.clear      = 1'b0;
        bus.word_ready = 1'b0;
        #12;
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        check("rst_fill", 32'(bus.fill_level), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_data", 32'(bus.word_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Direct path, 1,0,1,1,0,0,1,0 -> B2
        send_word(8'hB2);
        check("direct_valid", 32'(bus.word_valid), 32'd1);
        check("direct_fill", 32'(bus.fill_level), 32'd1);
        pop_word("direct", 8'hB2);
        check("direct_empty", 32'(bus.fill_level), 32'd0);

        // Debias: 10,00,01,11 then 10 x6 -> 1,0,1,1,1,1,1,1 = BF
        bus.debias_en = 1'b1;
        send_bit(1); send_bit(0);
        send_bit(0); send_bit(0);
        send_bit(0); send_bit(1);
        send_bit(1); send_bit(1);
        check("debias_partial", 32'(bus.fill_level), 32'd0);
        for (int i = 0; i < 6; i++) begin
            send_bit(1); send_bit(0);
        end
        check("debias_fill", 32'(bus.fill_level), 32'd1);
        pop_word("debias", 8'hBF);
        check("debias_one_word", 32'(bus.fill_level), 32'd0);
        bus.debias_en = 1'b0;

        // Push with ready high into an empty FIFO: push succeeds, no pop
        bus.word_ready = 1'b1;
        send_word(8'h3C);
        bus.word_ready = 1'b0;
        check("empty_pp_fill", 32'(bus.fill_level), 32'd1);
        check("empty_pp_data", 32'(bus.word_data), 32'h3C);
        pop_word("empty_pp", 8'h3C);

        // Overflow: five words with ready low
        for (int w = 1; w <= 5; w++) send_word(8'(w));
        check("ovf_fill", 32'(bus.fill_level), 32'd4);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        pop_word("ovf_w1", 8'h01);
        pop_word("ovf_w2", 8'h02);
        pop_word("ovf_w3", 8'h03);
        pop_word("ovf_w4", 8'h04);
        check("ovf_drained", 32'(bus.word_valid), 32'd0);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        do_clear();
        check("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Full FIFO, simultaneous push and pop
        for (int w = 16; w <= 19; w++) send_word(8'(w));
        check("fullpp_pre", 32'(bus.fill_level), 32'd4);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h14 >> i));
        bus.word_ready = 1'b1;
        send_bit(1'b0);
        bus.word_ready = 1'b0;
        check("fullpp_fill", 32'(bus.fill_level), 32'd4);
        check("fullpp_ovf", 32'(bus.overflow), 32'd0);
        pop_word("fullpp_w1", 8'h11);
        pop_word("fullpp_w2", 8'h12);
        pop_word("fullpp_w3", 8'h13);
        pop_word("fullpp_w4", 8'h14);

        // Asynchronous reset with a stored word and a partial word
        send_word(8'hAA);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        rst_n = 1'b0;
        #2;
        check("arst_valid", 32'(bus.word_valid), 32'd0);
        check("arst_fill", 32'(bus.fill_level), 32'd0);
        check("arst_data", 32'(bus.word_data), 32'd0);
        check("arst_ovf", 32'(bus.overflow), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'hFF);
        check("arst_fill_after", 32'(bus.fill_level), 32'd1);
        pop_word("arst_word", 8'hFF);

        // Clear beats bit_valid and pop on the same edge
        send_word(8'h21);
        send_word(8'h22);
        check("clr_pre", 32'(bus.fill_level), 32'd2);
        bus.clear      = 1'b1;
        bus.bit_valid  = 1'b1;
        bus.bit_in     = 1'b1;
        bus.word_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.clear      = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.word_ready = 1'b0;
        check("clr_fill", 32'(bus.fill_level), 32'd0);
        check("clr_valid", 32'(bus.word_valid), 32'd0);
        send_word(8'h5A);
        check("clr_fill_after", 32'(bus.fill_level), 32'd1);
        pop_word("clr_word", 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
